// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key event decoder.
// The optional modifier tracker in ps2_keyevent is enabled by PS2_MODIFIER_TRACK_EN.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0,
    StPause
  } dec_state_e;

  localparam logic [7:0] PrefixE0 = 8'hE0;
  localparam logic [7:0] PrefixF0 = 8'hF0;
  localparam logic [7:0] PrefixE1 = 8'hE1;

  // Bytes that follow the Pause-start E1 before the sequence is complete.
  localparam logic [2:0] PauseLen = 3'd7;

  localparam logic [7:0] ScShiftL = 8'h12;
  localparam logic [7:0] ScShiftR = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScAlt    = 8'h11;

  localparam int unsigned NumMods   = 6;
  localparam int unsigned ModLShift = 0;
  localparam int unsigned ModRShift = 1;
  localparam int unsigned ModLCtrl  = 2;
  localparam int unsigned ModRCtrl  = 3;
  localparam int unsigned ModLAlt   = 4;
  localparam int unsigned ModRAlt   = 5;

  localparam int unsigned EvWidth = 10;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_event_t;

  // Keyboard status/response bytes that never form part of a key event.
  function automatic logic is_ctrl(logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; Depth must be a power of two.
// A push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountFull);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PtrOne;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CountOne;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CountOne;
      end
    end
  end

endmodule

// File: rtl/ps2_keyevent.sv
// Turns the PS/2 set-2 byte stream into key events queued in a FWFT FIFO.
// Define PS2_MODIFIER_TRACK_EN to track shift/ctrl/alt state on the mods output.
import ps2_pkg::*;

module ps2_keyevent #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic [5:0] mods
);

  dec_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               sym_ready_q;
  logic               ovf_q;
  logic               accept;
  logic               emit;
  key_event_t         ev_d;
  logic [EvWidth-1:0] ev_raw, head_raw;
  logic               fifo_full, fifo_empty;
  logic               pop;

  assign accept = sym_valid & sym_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    ev_d    = '{code: sym_data, ext: 1'b0, rel: 1'b0};
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (sym_data == PrefixE0) begin
            state_d = StE0;
          end else if (sym_data == PrefixF0) begin
            state_d = StF0;
          end else if (sym_data == PrefixE1) begin
            state_d = StPause;
            cnt_d   = PauseLen;
          end else if (!is_ctrl(sym_data)) begin
            emit = 1'b1;
          end
        end
        StE0: begin
          if (sym_data == PrefixF0) begin
            state_d = StE0F0;
          end else if (sym_data == PrefixE0) begin
            state_d = StE0;
          end else if (sym_data == PrefixE1) begin
            state_d = StPause;
            cnt_d   = PauseLen;
          end else begin
            state_d  = StIdle;
            emit     = !is_ctrl(sym_data);
            ev_d.ext = 1'b1;
          end
        end
        // E1 is not a prefix after F0, so it decodes as an ordinary release.
        StF0: begin
          if (sym_data == PrefixE0) begin
            state_d = StE0;
          end else if (sym_data == PrefixF0) begin
            state_d = StF0;
          end else begin
            state_d  = StIdle;
            emit     = !is_ctrl(sym_data);
            ev_d.rel = 1'b1;
          end
        end
        StE0F0: begin
          if (sym_data == PrefixE0) begin
            state_d = StE0;
          end else if (sym_data == PrefixF0) begin
            state_d = StE0F0;
          end else begin
            state_d  = StIdle;
            emit     = !is_ctrl(sym_data);
            ev_d.ext = 1'b1;
            ev_d.rel = 1'b1;
          end
        end
        StPause: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = StIdle;
            emit    = 1'b1;
            ev_d    = '{code: PrefixE1, ext: 1'b1, rel: 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sym_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_ready_q <= 1'b1;
      // A drop in the same cycle as a clear must leave the flag set.
      if (emit && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ev_raw = ev_d;
  assign pop    = ev_valid & ev_ready;

  sync_fifo #(
    .Width(EvWidth),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (emit),
    .wdata(ev_raw),
    .pop  (pop),
    .rdata(head_raw),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign {ev_code, ev_ext, ev_release} = head_raw;
  assign ev_valid  = ~fifo_empty;
  assign sym_ready = sym_ready_q;
  assign ovf       = ovf_q;

`ifdef PS2_MODIFIER_TRACK_EN
  logic [NumMods-1:0] mods_q, mods_d;

  // Tracks every decoded event, including ones the FIFO had to drop.
  always_comb begin
    mods_d = mods_q;
    if (emit) begin
      if (ev_d.code == ScShiftL && !ev_d.ext) mods_d[ModLShift] = ~ev_d.rel;
      if (ev_d.code == ScShiftR && !ev_d.ext) mods_d[ModRShift] = ~ev_d.rel;
      if (ev_d.code == ScCtrl && !ev_d.ext)   mods_d[ModLCtrl]  = ~ev_d.rel;
      if (ev_d.code == ScCtrl && ev_d.ext)    mods_d[ModRCtrl]  = ~ev_d.rel;
      if (ev_d.code == ScAlt && !ev_d.ext)    mods_d[ModLAlt]   = ~ev_d.rel;
      if (ev_d.code == ScAlt && ev_d.ext)     mods_d[ModRAlt]   = ~ev_d.rel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mods_q <= '0;
    end else begin
      mods_q <= mods_d;
    end
  end

  assign mods = mods_q;
`else
  assign mods = 6'b0;
`endif

endmodule

// File: tb/tb_ps2_keyevent.sv
// Directed and randomized bench for ps2_keyevent against a prefix-flag reference model.
// Honours PS2_MODIFIER_TRACK_EN the same way the design does.
module tb_ps2_keyevent;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0] CTRL [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  localparam logic [7:0] MODK [4] = '{8'h12, 8'h59, 8'h14, 8'h11};
  // {ext, code} of the key controlling each mods bit, index = bit number.
  localparam logic [8:0] MOD_KEYS [6] = '{9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sym_data = 8'h00;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic [7:0] ev_code;
  logic       ev_ext, ev_release, ev_valid;
  logic       ev_ready = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
  logic [5:0] mods;

  always #5 clk = ~clk;

  ps2_keyevent #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_release(ev_release),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .mods      (mods)
  );

  // Reference model: pending prefix flags, pause byte budget, queue of events.
  logic [9:0] q[$];
  bit         m_e0, m_f0, m_sr, m_ovf;
  int         m_pause;
  logic [5:0] m_mods;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q.delete();
    m_e0 = 0; m_f0 = 0; m_sr = 0; m_ovf = 0; m_pause = 0; m_mods = '0;
  endtask

  task automatic model_emit(input logic [7:0] c, input bit x, input bit r, inout bit set);
    if (q.size() < DEPTH) q.push_back({c, x, r});
    else set = 1;
`ifdef PS2_MODIFIER_TRACK_EN
    for (int i = 0; i < 6; i++) if ({x, c} == MOD_KEYS[i]) m_mods[i] = !r;
`endif
  endtask

  task automatic model_byte(input logic [7:0] b, inout bit set);
    bit ctrl;
    ctrl = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) model_emit(8'hE1, 1, 0, set);
    end else if (b == 8'hE0) begin
      m_e0 = 1; m_f0 = 0;
    end else if (b == 8'hF0) begin
      m_f0 = 1;
    end else if (b == 8'hE1 && !m_f0) begin
      m_pause = 7; m_e0 = 0;
    end else begin
      if (!ctrl) model_emit(b, m_e0, m_f0, set);
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  // Drive one cycle from a negedge, advance the model, then compare at the next negedge.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
    bit set;
    sym_valid = v; sym_data = d; ev_ready = rdy; ovf_clr = clr;
    set = 0;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (v && m_sr) model_byte(d, set);
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_sr = 1;
    @(negedge clk);
    check("sym_ready", sym_ready, m_sr);
    check("ev_valid", ev_valid, q.size() != 0);
    if (q.size() != 0) check("ev_head", {ev_code, ev_ext, ev_release}, q[0]);
    check("ovf", ovf, m_ovf);
    check("mods", mods, m_mods);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; sym_valid = 0; ev_ready = 0; ovf_clr = 0;
    #1;
    check("rst_sym_ready", sym_ready, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_head", {ev_code, ev_ext, ev_release}, 0);
    check("rst_ovf", ovf, 0);
    check("rst_mods", mods, 0);
    model_clear();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    step(1, b, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    do_reset();
    // The first byte after reset meets sym_ready low and is lost.
    send(8'h1C, 0);

    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); idle(3, 1);
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    idle(3, 1);
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0);
    idle(2, 1);
    for (int i = 0; i < 6; i++) send(8'h15 + 8'(i), 0);
    step(0, 8'h00, 0, 1);
    idle(5, 1);
    send(8'hAA, 0); send(8'hFA, 0); send(8'hF0, 0); send(8'hFE, 0); send(8'h1C, 0);
    idle(2, 1);

    send(8'h12, 1); send(8'hE0, 1); send(8'h14, 1);
`ifdef PS2_MODIFIER_TRACK_EN
    check("mods_make", mods, 6'b001001);
`endif
    send(8'hF0, 1); send(8'h12, 1);
`ifdef PS2_MODIFIER_TRACK_EN
    check("mods_break", mods, 6'b001000);
`endif
    send(8'hE0, 1);
    do_reset();
    idle(1, 0);
    send(8'h14, 0);
    check("post_rst_ev", {ev_valid, ev_code, ev_ext, ev_release}, {1'b1, 8'h14, 2'b00});
`ifdef PS2_MODIFIER_TRACK_EN
    check("post_rst_mods", mods, 6'b000100);
`endif
    idle(2, 1);

    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      r = int'($urandom_range(0, 19));
      if (r < 3) b = 8'hE0;
      else if (r < 6) b = 8'hF0;
      else if (r == 6) b = 8'hE1;
      else if (r < 9) b = CTRL[$urandom_range(0, 5)];
      else if (r < 13) b = MODK[$urandom_range(0, 3)];
      else b = 8'($urandom);
      step($urandom_range(0, 3) != 0, b, ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                              : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15) == 0);
    end
    idle(DEPTH + 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
